// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: load/store funct3 encodings, the load/store FSM
// state type and a byte-enable helper.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-lane enables from access size (funct3[1:0]) and byte offset.
  function automatic logic [3:0] byte_enables(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << offset;
      2'b01:   be = 4'b0011 << offset;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load alignment: picks the addressed lane out of the read word and
// sign- or zero-extends it according to funct3.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Move the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// RV32I load/store unit: one access per request over a single-outstanding
// req/ready data-memory port, with local trapping of misaligned accesses and
// illegal funct3 encodings.
module mem_access
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  state_t      state;
  logic        is_load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;

  logic        req_fault;
  logic        req_noop;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [31:0] aligned;

  assign busy = (state != ST_IDLE);

  // Classify the incoming request: fault, no-op, or a real memory access.
  always_comb begin
    req_fault = 1'b0;
    req_noop  = !mem_read && !mem_write;
    if (mem_read && mem_write) begin
      req_fault = 1'b1;
    end else if (mem_read) begin
      case (funct3)
        F3_B, F3_BU: req_fault = 1'b0;
        F3_H, F3_HU: req_fault = addr[0];
        F3_W:        req_fault = (addr[1:0] != 2'b00);
        default:     req_fault = 1'b1;
      endcase
    end else if (mem_write) begin
      case (funct3)
        F3_B:    req_fault = 1'b0;
        F3_H:    req_fault = addr[0];
        F3_W:    req_fault = (addr[1:0] != 2'b00);
        default: req_fault = 1'b1;
      endcase
    end
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    req_be = byte_enables(funct3[1:0], addr[1:0]);
    case (funct3[1:0])
      2'b00:   req_wdata = {4{wdata[7:0]}};
      2'b01:   req_wdata = {2{wdata[15:0]}};
      default: req_wdata = wdata;
    endcase
  end

  load_align u_load_align (
    .rdata     (dmem_rdata),
    .offset    (offset_q),
    .funct3    (funct3_q),
    .load_data (aligned)
  );

  // Request FSM; the memory port and writeback outputs are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_load_q  <= 1'b0;
      funct3_q   <= '0;
      offset_q   <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      load_data  <= '0;
      wb_rd      <= '0;
      wb_we      <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      wb_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_load_q <= mem_read;
            funct3_q  <= funct3;
            offset_q  <= addr[1:0];
            wb_rd     <= rd;
            if (req_fault || req_noop) begin
              state <= ST_DONE;
              done  <= 1'b1;
              fault <= req_fault;
            end else begin
              state      <= ST_REQ;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_be    <= req_be;
              dmem_wdata <= req_wdata;
            end
          end
        end
        ST_REQ: begin
          if (dmem_ready) begin
            state    <= ST_DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            done     <= 1'b1;
            wb_we    <= is_load_q;
            if (is_load_q) begin
              load_data <= aligned;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a vector table of single accesses plus
// hand-written sequences for wait states, start-while-busy and async reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rd         (rd),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata)
  );

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;    // REQ cycles with ready low before the ready cycle
    logic        e_fault;
    logic        e_req;
    logic        e_we;     // expected wb_we
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic r, input logic w, input logic [2:0] f,
                           input logic [31:0] a, input logic [31:0] d, input logic [4:0] r_d);
    start     = 1'b1;
    mem_read  = r;
    mem_write = w;
    funct3    = f;
    addr      = a;
    wdata     = d;
    rd        = r_d;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          req_cnt;
    int          done_cyc;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    req_cnt  = 0;
    done_cyc = 0;
    a0 = '0; be0 = '0; wd0 = '0;
    @(negedge clk);
    drive_req(v.rd_en, v.wr_en, v.f3, v.addr, v.wdata, v.rd);
    dmem_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (dmem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          a0 = dmem_addr; be0 = dmem_be; wd0 = dmem_wdata;
          chk($sformatf("v%0d.addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d.be", idx), {28'd0, dmem_be}, {28'd0, v.e_be});
          chk($sformatf("v%0d.we", idx), {31'd0, dmem_we}, {31'd0, v.wr_en});
          if (v.wr_en)
            chk($sformatf("v%0d.wdata", idx), dmem_wdata, v.e_wdata);
        end else begin
          chk($sformatf("v%0d.addr_stable", idx), dmem_addr, a0);
          chk($sformatf("v%0d.be_stable", idx), {28'd0, dmem_be}, {28'd0, be0});
          chk($sformatf("v%0d.wdata_stable", idx), dmem_wdata, wd0);
        end
        dmem_ready = (req_cnt == v.delay + 1);
        dmem_rdata = v.rdata;
      end
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d.fault", idx), {31'd0, fault}, {31'd0, v.e_fault});
        chk($sformatf("v%0d.wb_we", idx), {31'd0, wb_we}, {31'd0, v.e_we});
        chk($sformatf("v%0d.wb_rd", idx), {27'd0, wb_rd}, {27'd0, v.rd});
        if (v.e_we)
          chk($sformatf("v%0d.load_data", idx), load_data, v.e_load);
        break;
      end
    end
    dmem_ready = 1'b0;
    chk($sformatf("v%0d.done_cycle", idx), done_cyc, v.e_req ? v.delay + 2 : 1);
    chk($sformatf("v%0d.req_cycles", idx), req_cnt, v.e_req ? v.delay + 1 : 0);
    @(negedge clk);
    chk($sformatf("v%0d.done_pulse", idx), {31'd0, done}, 32'd0);
    chk($sformatf("v%0d.idle", idx), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd1, 32'h0, 0, 1'b0, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 32'h80FF1234, 0, 1'b0, 1'b1, 1'b1, 4'h8, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd5, 32'h80FF1234, 1, 1'b0, 1'b1, 1'b1, 4'h8, 32'h0, 32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5'd2, 32'h0, 0, 1'b0, 1'b1, 1'b0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd4, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 5'd6, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd7, 32'h80FF1234, 1, 1'b0, 1'b1, 1'b1, 4'hC, 32'h0, 32'hFFFF80FF};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 5'd8, 32'h80FF1234, 0, 1'b0, 1'b1, 1'b1, 4'h3, 32'h0, 32'h00001234};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h123456A5, 5'd9, 32'h0, 0, 1'b0, 1'b1, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 5'd10, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0, 32'h0, 5'd11, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 5'd12, 32'h0, 0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h201, 32'h0, 5'd13, 32'h0, 0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 5'd14, 32'hCAFEF00D, 2, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd15, 32'h0000007F, 0, 1'b0, 1'b1, 1'b1, 4'h1, 32'h0, 32'h0000007F};

    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = '0; addr = '0; wdata = '0; rd = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk("rst.dmem_be", {28'd0, dmem_be}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Ready held low for three REQ cycles, with start pulsed meanwhile
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd7);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("wait%0d.req", i), {31'd0, dmem_req}, 32'd1);
      chk($sformatf("wait%0d.addr", i), dmem_addr, 32'h300);
      chk($sformatf("wait%0d.be", i), {28'd0, dmem_be}, 32'hF);
      chk($sformatf("wait%0d.we", i), {31'd0, dmem_we}, 32'd0);
      chk($sformatf("wait%0d.done", i), {31'd0, done}, 32'd0);
      if (i == 2) drive_req(1'b0, 1'b1, 3'b010, 32'h500, 32'h12345678, 5'd3);
      else start = 1'b0;
      dmem_ready = (i == 4);
      dmem_rdata = 32'hA5A50001;
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("wait.done", {31'd0, done}, 32'd1);
    chk("wait.req_low", {31'd0, dmem_req}, 32'd0);
    chk("wait.load_data", load_data, 32'hA5A50001);
    chk("wait.wb_rd", {27'd0, wb_rd}, 32'd7);
    chk("wait.wb_we", {31'd0, wb_we}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wait.no_second_req", {31'd0, dmem_req}, 32'd0);
      chk("wait.no_second_done", {31'd0, done}, 32'd0);
    end

    // Asynchronous reset in the second REQ cycle
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd3);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("arst.req_c1", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    chk("arst.req_c2", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst.req_drop", {31'd0, dmem_req}, 32'd0);
    chk("arst.busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst.no_done", {31'd0, done}, 32'd0);
      chk("arst.no_req", {31'd0, dmem_req}, 32'd0);
    end
    run_vec('{1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 5'd9, 32'h11223344, 0,
              1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h11223344}, 99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
